muldiv_hilo: RTL and testbench



---
 rtl/muldiv_hilo_if.sv | 28 ++
 rtl/muldiv_hilo.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the CPU datapath and the multiply/divide unit.
// The master side issues operations and mthi/mtlo writes; the slave side owns HI/LO.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply / restoring divide with integrated HI/LO registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise every op is unsigned.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; HI/LO hold last result or mthi/mtlo data
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_hilo_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;
  logic                 dz_pend_q, dz_pend_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, fix_prod;
  logic [WIDTH-1:0]     fix_rem, fix_quo, fix_hi, fix_lo;

  // Operand magnitudes and result sign flags; the unsigned build drops all of it.
`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_hi_q, neg_hi_d;
  logic neg_lo_q, neg_lo_d;

  assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = a_neg ? -bus.a : bus.a;
  assign mag_b = b_neg ? -bus.b : bus.b;

  assign fix_prod = neg_lo_q ? -acc_q : acc_q;
  assign fix_rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_quo  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`else
  logic unused_op0;

  assign unused_op0 = bus.op[0];
  assign mag_a      = bus.a;
  assign mag_b      = bus.b;

  assign fix_prod = acc_q;
  assign fix_rem  = acc_q[2*WIDTH-1:WIDTH];
  assign fix_quo  = acc_q[WIDTH-1:0];
`endif

  assign fix_hi = is_div_q ? fix_rem : fix_prod[2*WIDTH-1:WIDTH];
  assign fix_lo = is_div_q ? fix_quo : fix_prod[WIDTH-1:0];

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    dz_pend_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
`endif

    if (bus.wr_hi) hi_d = bus.wr_data;
    if (bus.wr_lo) lo_d = bus.wr_data;

    if (dz_pend_q) begin
      done_d     = 1'b1;
      div_zero_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op[1] && (bus.b == '0)) begin
            dz_pend_d = 1'b1;
          end else begin
            state_d  = RUN;
            cnt_d    = CNT_LOAD;
            is_div_d = bus.op[1];
            acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            opnd_d   = bus.op[1] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = bus.op[1] ? a_neg : (a_neg ^ b_neg);
`endif
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        // Result overrides any mthi/mtlo landing on the same edge.
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      dz_pend_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      dz_pend_q  <= dz_pend_d;
`ifdef MULDIV_SIGNED_EN
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
`endif
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: vector table plus multi-cycle corner sequences.
// Expected values follow MULDIV_SIGNED_EN so the bench fits either build.
module tb_muldiv_hilo;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  muldiv_hilo_if #(.WIDTH(W)) bus ();

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called right after the accepting edge; lat counts edges from that edge to done.
  task automatic wait_done(output int lat, output bit busy_seen);
    lat       = 0;
    busy_seen = bus.busy;
    while (!bus.done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_seen = 1'b1;
    end
  endtask

  vec_t vecs [9];

  initial begin
    int  lat;
    bit  busy_seen;
    bit  done_seen;

    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
`ifdef MULDIV_SIGNED_EN
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{OP_MULT,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF6};
    vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
`else
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[6] = '{OP_MULT,  32'd5,         32'hFFFF_FFFE, 32'h0000_0004, 32'hFFFF_FFF6};
    vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi",       bus.hi,       0);
    chk("reset_lo",       bus.lo,       0);
    chk("reset_busy",     bus.busy,     0);
    chk("reset_done",     bus.done,     0);
    chk("reset_div_zero", bus.div_zero, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_run", i), bus.busy, 1);
      wait_done(lat, busy_seen);
      chk($sformatf("v%0d_latency", i),  lat,          LAT);
      chk($sformatf("v%0d_hi", i),       bus.hi,       vecs[i].hi);
      chk($sformatf("v%0d_lo", i),       bus.lo,       vecs[i].lo);
      chk($sformatf("v%0d_div_zero", i), bus.div_zero, 0);
      chk($sformatf("v%0d_busy_done", i), bus.busy,    0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    end

    // mthi/mtlo preload, then divide by zero must leave HI/LO alone
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h0000_5678;
    @(posedge clk);
    #1;
    bus.wr_lo   = 1'b0;
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, busy_seen);
    chk("dz_latency",  lat,          1);
    chk("dz_flag",     bus.div_zero, 1);
    chk("dz_hi",       bus.hi,       32'h1234);
    chk("dz_lo",       bus.lo,       32'h5678);
    chk("dz_busy",     busy_seen,    0);
    @(posedge clk);
    #1;
    chk("dz_done_pulse", bus.done,     0);
    chk("dz_flag_pulse", bus.div_zero, 0);

    // MULTU 3x3 with a stray start, a mid-RUN mtlo and an mthi on the FIX edge
    issue(OP_MULTU, 32'd3, 32'd3);
    lat = 0;
    while (!bus.done && lat < 80) begin
      if (lat == 3) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
      end
      if (lat == 4) bus.start = 1'b0;
      if (lat == 10) begin
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_AAAA;
      end
      if (lat == 11) bus.wr_lo = 1'b0;
      if (lat == LAT - 1) begin
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0000_5555;
      end
      @(posedge clk);
      #1;
      lat++;
      bus.wr_hi = 1'b0;
    end
    chk("ign_latency", lat,    LAT);
    chk("ign_hi",      bus.hi, 0);
    chk("ign_lo",      bus.lo, 9);

    // start in the done cycle is taken with no bubble
    issue(OP_MULTU, 32'd5, 32'd5);
    chk("b2b_busy", bus.busy, 1);
    wait_done(lat, busy_seen);
    chk("b2b_latency", lat,    LAT);
    chk("b2b_hi",      bus.hi, 0);
    chk("b2b_lo",      bus.lo, 25);

    // reset mid-operation aborts without a done pulse
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi",   bus.hi,   0);
    chk("rst_lo",   bus.lo,   0);
    chk("rst_done", bus.done, 0);
    reset     = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    chk("rst_no_done", done_seen, 0);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done(lat, busy_seen);
    chk("post_rst_latency", lat,    LAT);
    chk("post_rst_hi",      bus.hi, 0);
    chk("post_rst_lo",      bus.lo, 42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
